// File: rtl/reg_nway_mux.sv
// Registered N-way multiplexer with a valid/ready handshake on every channel.
// MODE 0 takes the channel named by S; MODE 1 round-robins among valid channels.
module reg_nway_mux #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    parameter  int MODE  = 0,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N*WIDTH-1:0]   I,
    input  logic [N-1:0]         V,
    output logic [N-1:0]         R,
    input  logic [SELW-1:0]      S,
    output logic [WIDTH-1:0]     Y,
    output logic                 YV,
    input  logic                 YR
);

    logic            ld;
    logic            acc;
    logic [N-1:0]    g;
    logic [SELW-1:0] sel;
    logic [SELW-1:0] p;
    logic [SELW-1:0] p_next;

    // NOTE: every signal gets a default at the top of always_comb, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        g   = '0;
        sel = '0;
        idx = 0;
        if (MODE == 0) begin
            for (int k = 0; k < N; k++) begin
                if (int'(S) == k && V[k]) begin
                    g[k] = 1'b1;
                    sel  = SELW'(k);
                end
            end
        end else begin
            // Scan backwards from the far end so the last hit is the nearest valid channel at or after p.
            for (int j = N - 1; j >= 0; j--) begin
                idx = (int'(p) + j) % N;
                if (V[idx]) begin
                    g      = '0;
                    g[idx] = 1'b1;
                    sel    = SELW'(idx);
                end
            end
        end
    end

    assign ld     = !YV || YR;
    assign R      = RST ? '0 : (g & {N{ld}});
    assign acc    = |R;
    assign p_next = (int'(sel) == N - 1) ? '0 : sel + 1'b1;

    // NOTE: state is updated with <= so all registers sample values from before the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Y  <= '0;
            YV <= 1'b0;
            p  <= '0;
        end else if (acc) begin
            Y  <= I[sel*WIDTH +: WIDTH];
            YV <= 1'b1;
            if (MODE == 1) begin
                p <= p_next;
            end
        end else if (YV && YR) begin
            YV <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_nway_mux.sv
// Bench for reg_nway_mux: explicit-select and round-robin instances share stimulus;
// per-cycle vector tables check ready/valid, a scoreboard queue checks output data.
module tb_reg_nway_mux;

    typedef struct {
        logic [3:0] v;
        logic [1:0] s;
        logic       yr;
        logic [3:0] r;
        logic       yv;
    } vec_t;
    typedef vec_t vec_q_t[$];

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] I   = 32'h4433_2211;
    logic [3:0]  V   = '0;
    logic [1:0]  S   = '0;
    logic        YR  = 1'b1;

    logic [3:0] r0, r1;
    logic [2:0] r2;
    logic [7:0] y0, y1, y2;
    logic       yv0, yv1, yv2;

    logic [3:0] r_act;
    logic [7:0] y_act;
    logic       yv_act;

    int         errors = 0;
    int         checks = 0;
    int         which  = 0;
    logic [7:0] sb[$];
    logic [7:0] last_y;
    vec_q_t     t0, t1, t2, t3, t4;

    always #5 CLK = ~CLK;

    reg_nway_mux #(.WIDTH(8), .N(4), .MODE(0)) dut0 (
        .CLK(CLK), .RST(RST), .I(I), .V(V), .R(r0), .S(S),
        .Y(y0), .YV(yv0), .YR(YR)
    );

    reg_nway_mux #(.WIDTH(8), .N(4), .MODE(1)) dut1 (
        .CLK(CLK), .RST(RST), .I(I), .V(V), .R(r1), .S(S),
        .Y(y1), .YV(yv1), .YR(YR)
    );

    reg_nway_mux #(.WIDTH(8), .N(3), .MODE(0)) dut2 (
        .CLK(CLK), .RST(RST), .I(I[23:0]), .V(V[2:0]), .R(r2), .S(S),
        .Y(y2), .YV(yv2), .YR(YR)
    );

    always_comb begin
        case (which)
            1:       begin r_act = r1;          y_act = y1; yv_act = yv1; end
            2:       begin r_act = {1'b0, r2};  y_act = y2; yv_act = yv2; end
            default: begin r_act = r0;          y_act = y0; yv_act = yv0; end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Channel k carries 8'h11 * (k+1) in the fixed input word.
    function automatic logic [7:0] chan_data(input logic [3:0] r);
        logic [7:0] d = '0;
        for (int k = 0; k < 4; k++) begin
            if (r[k]) d = 8'((k + 1) * 17);
        end
        return d;
    endfunction

    task automatic do_reset();
        RST = 1'b1; V = 4'hF; S = '0; YR = 1'b1;
        repeat (2) begin
            #2;
            check("rst_r", r_act, 0);
            @(posedge CLK); #1;
            check("rst_yv", yv_act, 0);
            check("rst_y", y_act, 0);
        end
        RST = 1'b0;
        sb.delete();
        last_y = '0;
    endtask

    task automatic run_table(input string tag, input vec_q_t t);
        foreach (t[i]) begin
            V = t[i].v; S = t[i].s; YR = t[i].yr;
            #2;
            check($sformatf("%s[%0d] r", tag, i), r_act, t[i].r);
            check($sformatf("%s[%0d] yv", tag, i), yv_act, t[i].yv);
            if (t[i].yv) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s[%0d] y: got %h expected a queued word", tag, i, y_act);
                end else begin
                    check($sformatf("%s[%0d] y", tag, i), y_act, sb[0]);
                    if (t[i].yr) last_y = sb.pop_front();
                end
            end else begin
                check($sformatf("%s[%0d] y_hold", tag, i), y_act, last_y);
            end
            if (t[i].r != 0) sb.push_back(chan_data(t[i].r));
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        // Explicit select: step S, stall three cycles, release without a bubble, drop V, drain.
        t0.push_back('{4'hF, 2'd0, 1'b1, 4'b0001, 1'b0});
        t0.push_back('{4'hF, 2'd1, 1'b1, 4'b0010, 1'b1});
        t0.push_back('{4'hF, 2'd2, 1'b1, 4'b0100, 1'b1});
        t0.push_back('{4'hF, 2'd3, 1'b1, 4'b1000, 1'b1});
        t0.push_back('{4'hF, 2'd0, 1'b0, 4'b0000, 1'b1});
        t0.push_back('{4'hF, 2'd1, 1'b0, 4'b0000, 1'b1});
        t0.push_back('{4'h0, 2'd2, 1'b0, 4'b0000, 1'b1});
        t0.push_back('{4'hF, 2'd2, 1'b1, 4'b0100, 1'b1});
        t0.push_back('{4'b0100, 2'd1, 1'b1, 4'b0000, 1'b1});
        t0.push_back('{4'h0, 2'd1, 1'b1, 4'b0000, 1'b0});
        t0.push_back('{4'h1, 2'd0, 1'b0, 4'b0001, 1'b0});
        t0.push_back('{4'h0, 2'd0, 1'b1, 4'b0000, 1'b1});
        t0.push_back('{4'h0, 2'd0, 1'b1, 4'b0000, 1'b0});
        // Round-robin, all valid: grants 0,1,2,3 then wrap to 0; S must be ignored.
        t1.push_back('{4'hF, 2'd3, 1'b1, 4'b0001, 1'b0});
        t1.push_back('{4'hF, 2'd3, 1'b1, 4'b0010, 1'b1});
        t1.push_back('{4'hF, 2'd0, 1'b1, 4'b0100, 1'b1});
        t1.push_back('{4'hF, 2'd1, 1'b1, 4'b1000, 1'b1});
        t1.push_back('{4'hF, 2'd2, 1'b1, 4'b0001, 1'b1});
        t1.push_back('{4'h0, 2'd0, 1'b1, 4'b0000, 1'b1});
        t1.push_back('{4'h0, 2'd0, 1'b1, 4'b0000, 1'b0});
        // Round-robin skipping idle channels, then a stall that must not move the pointer.
        t2.push_back('{4'b1010, 2'd0, 1'b1, 4'b0010, 1'b0});
        t2.push_back('{4'b1010, 2'd0, 1'b1, 4'b1000, 1'b1});
        t2.push_back('{4'b1010, 2'd0, 1'b1, 4'b0010, 1'b1});
        t2.push_back('{4'b1010, 2'd0, 1'b0, 4'b0000, 1'b1});
        t2.push_back('{4'b1010, 2'd0, 1'b0, 4'b0000, 1'b1});
        t2.push_back('{4'b1010, 2'd0, 1'b0, 4'b0000, 1'b1});
        t2.push_back('{4'hF, 2'd0, 1'b1, 4'b0100, 1'b1});
        t2.push_back('{4'h0, 2'd0, 1'b1, 4'b0000, 1'b1});
        t2.push_back('{4'h0, 2'd0, 1'b1, 4'b0000, 1'b0});
        // Three channels: S=3 selects nothing and the output drains.
        t3.push_back('{4'hF, 2'd0, 1'b1, 4'b0001, 1'b0});
        t3.push_back('{4'hF, 2'd3, 1'b1, 4'b0000, 1'b1});
        t3.push_back('{4'hF, 2'd3, 1'b1, 4'b0000, 1'b0});
        t3.push_back('{4'hF, 2'd2, 1'b1, 4'b0100, 1'b0});
        t3.push_back('{4'hF, 2'd3, 1'b1, 4'b0000, 1'b1});
        t3.push_back('{4'hF, 2'd3, 1'b1, 4'b0000, 1'b0});
        // Load one word and stall on it ahead of a reset pulse.
        t4.push_back('{4'hF, 2'd1, 1'b1, 4'b0010, 1'b0});
        t4.push_back('{4'hF, 2'd1, 1'b0, 4'b0000, 1'b1});

        which = 0; do_reset(); run_table("m0", t0);
        which = 1; do_reset(); run_table("rr", t1);
        do_reset(); run_table("rr_skip", t2);
        which = 2; do_reset(); run_table("n3", t3);
        which = 0; do_reset(); run_table("mid", t4);

        // Reset while stalled on a held word: the word is discarded, never output.
        RST = 1'b1; YR = 1'b0;
        #2;
        check("mid_rst_r", r_act, 0);
        @(posedge CLK); #1;
        check("mid_rst_yv", yv_act, 0);
        check("mid_rst_y", y_act, 0);
        RST = 1'b0; V = '0; YR = 1'b1;
        #2;
        check("post_rst_r", r_act, 0);
        @(posedge CLK); #1;
        check("post_rst_yv", yv_act, 0);
        check("post_rst_y", y_act, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_nway_mux.md
REG_NWAY_MUX -- requirements
Module: reg_nway_mux

Parameters
REQ-001 WIDTH, default 8: data bits per channel, at least 1.
REQ-002 N, default 4: number of input channels, at least 2.
REQ-003 MODE, default 0: selection mode. 0 = explicit select, 1 = round-robin among valid inputs.
REQ-004 SELW, default $clog2(N): select width, derived and not overridden.

Interface
REQ-005 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-006 RST  in  1  reset, synchronous and active-high.
REQ-007 I    in  N*WIDTH  packed channel data; channel k sits at bits [k*WIDTH +: WIDTH].
REQ-008 V    in  N  per-channel valid.
REQ-009 R    out N  per-channel ready; combinational.
REQ-010 S    in  SELW  channel select; used only when MODE=0.
REQ-011 Y    out WIDTH  registered output data.
REQ-012 YV   out 1  output valid; registered.
REQ-013 YR   in  1  downstream ready.

Function
REQ-014 Transfer rules:
- An input transfer on channel k occurs when V[k] and R[k] are both 1.
- An output transfer occurs when YV and YR are both 1.
REQ-015 Load enable is LD = !YV || YR. The output register accepts new data only when LD=1.
REQ-016 Grant vector G is one-hot or zero. R[k] = G[k] && LD. At most one bit of R is 1 in any cycle.
REQ-017 MODE=0:
- G[k] = 1 iff k == S and V[k] = 1.
- If S >= N, G = 0 and no channel is accepted.
REQ-018 MODE=1:
- Pointer P (SELW bits) holds the highest-priority channel.
- G selects the first k with V[k]=1, scanning P, P+1, ... cyclically mod N.
- G = 0 when V = 0. S is ignored.
REQ-019 MODE=1 pointer update:
- On an input transfer from channel k, P <= (k+1) mod N.
- With k = N-1, P wraps to 0.
- Otherwise P holds, including while stalled.
REQ-020 Input transfer on channel k: at the edge, Y <= I[k*WIDTH +: WIDTH] and YV <= 1. Latency is 1 cycle from accept to YV.
REQ-021 Output transfer with no input transfer in the same cycle: YV <= 0 and Y holds its last value.
REQ-022 Output and input transfer in the same cycle: the register reloads with the new data and YV stays 1. Full throughput of 1 word per cycle is sustained.
REQ-023 YV=1 and YR=0 (stall):
- Y and YV hold.
- R = 0.
- P holds.
- Input data is not sampled.
REQ-024 Once YV=1, Y is stable until the output transfer completes. Changes on V or S during a stall do not affect Y.
REQ-025 V[k] deasserting before its transfer is legal. No data from that channel is captured.
REQ-026 No internal FIFO. Storage is the single output register plus P.

Reset
REQ-027 RST=1 at a rising edge sets Y=0, YV=0 and P=0, overriding any simultaneous transfer.
REQ-028 While RST=1, R=0.
REQ-029 A word held in Y when RST asserts is discarded.
REQ-030 On the first edge after RST deasserts, normal transfers are allowed.

Verification
REQ-031 Reset: assert RST for 2 cycles with all V=1 -> Y=0, YV=0, R=0 throughout. First accept occurs 1 cycle after release.
REQ-032 MODE=0, N=4, WIDTH=8, I={8'h44,8'h33,8'h22,8'h11}, V=4'hF, YR=1:
- Step S through 0..3 -> Y = 11,22,33,44 on consecutive cycles, YV=1 continuous.
- S=3'd4 is not applicable, since SELW=2 for N=4.
- With N=3, S=2'd3 -> R=0 and YV drops after the drain.
REQ-033 MODE=1, N=4, V=4'hF, YR=1:
- Grants go 0,1,2,3,0 on successive cycles.
- P wraps 3 -> 0.
REQ-034 MODE=1, V=4'b1010, P=0 -> grants 1, then 3, then 1 (skips idle channels).
REQ-035 Backpressure: YR=0 for 3 cycles with YV=1 -> Y held, R=0, P unchanged. On YR=1, the next word loads in the same cycle with no bubble.
REQ-036 Reset mid-stall: YV=1, YR=0, pulse RST -> YV=0 and Y=0 next cycle. The pending word is never output.
